// File: rtl/post_adder_acc_if.sv
// post_adder_acc_if: operand, control and result bundle for the post-adder/accumulator
interface post_adder_acc_if;
  logic        cep;
  logic        ceopmode;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] dab;
  logic [47:0] c;
  logic [47:0] pcin;
  logic        carryin;
  logic [47:0] p;
  logic [47:0] pcout;
  logic        carryout;
  logic        carryoutf;
  modport master (output cep, ceopmode, opmode, m, dab, c, pcin, carryin,
                  input p, pcout, carryout, carryoutf);
  modport slave (input cep, ceopmode, opmode, m, dab, c, pcin, carryin,
                 output p, pcout, carryout, carryoutf);
endinterface

// File: rtl/post_adder_acc.sv
// post_adder_acc: DSP-style X/Z mux post-adder with optional P and opmode registers
module post_adder_acc #(
  parameter int PREG       = 1,
  parameter int OPMODEREG  = 1,
  parameter     CARRYINSEL = "OPMODE5"
) (
  input  logic           clk,
  input  logic           rst,
  post_adder_acc_if.slave b
);
  logic [7:0]  opr, op;
  logic [47:0] preg, pfb, x, z;
  logic        creg, cin;
  logic [48:0] xe, sum;
  logic        unused_op;
  always_ff @(posedge clk)
    if (rst) opr <= '0;
    else if (b.ceopmode) opr <= b.opmode;
  assign op = (OPMODEREG != 0) ? opr : b.opmode;
  assign unused_op = ^{op[6], op[4], b.carryin};
  // Without a P register the feedback path would be a combinational loop
  assign pfb = (PREG != 0) ? preg : 48'd0;
  assign x = op[1:0] == 2'd0 ? 48'd0 : op[1:0] == 2'd1 ? {12'd0, b.m} : op[1:0] == 2'd2 ? pfb : b.dab;
  assign z = op[3:2] == 2'd0 ? 48'd0 : op[3:2] == 2'd1 ? b.pcin : op[3:2] == 2'd2 ? pfb : b.c;
  assign cin = (CARRYINSEL == "OPMODE5") ? op[5] : (CARRYINSEL == "CARRYIN") ? b.carryin : 1'b0;
  assign xe = {1'b0, x} + {48'd0, cin};
  assign sum = op[7] ? {1'b0, z} - xe : {1'b0, z} + xe;
  always_ff @(posedge clk)
    if (rst) {creg, preg} <= '0;
    else if (b.cep) {creg, preg} <= sum;
  assign b.p = (PREG != 0) ? preg : sum[47:0];
  assign b.carryout = (PREG != 0) ? creg : sum[48];
  assign b.pcout = b.p;
  assign b.carryoutf = b.carryout;
endmodule

// File: tb/tb_post_adder_acc.sv
// tb_post_adder_acc: three configurations driven together and checked against an arithmetic model
module tb_post_adder_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [47:0] p0 = '0, p1 = '0;
  logic c0 = 1'b0, c1 = 1'b0;
  logic [7:0] o1 = '0;

  post_adder_acc_if i0 ();
  post_adder_acc_if i1 ();
  post_adder_acc_if i2 ();

  post_adder_acc #(.PREG(1), .OPMODEREG(0)) u0 (.clk(clk), .rst(rst), .b(i0.slave));
  post_adder_acc u1 (.clk(clk), .rst(rst), .b(i1.slave));
  post_adder_acc #(.PREG(0), .OPMODEREG(0), .CARRYINSEL("CARRYIN")) u2 (.clk(clk), .rst(rst), .b(i2.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pick(input logic [1:0] s, input logic [47:0] a1, input logic [47:0] a2, input logic [47:0] a3);
    return s == 2'd0 ? 48'd0 : s == 2'd1 ? a1 : s == 2'd2 ? a2 : a3;
  endfunction

  function automatic logic [48:0] alu(input logic [7:0] o, input logic [47:0] pf, input logic [35:0] mm,
                                      input logic [47:0] dd, input logic [47:0] cc, input logic [47:0] pc, input logic ci);
    longint unsigned x, z, r;
    x = 64'(pick(o[1:0], {12'd0, mm}, pf, dd));
    z = 64'(pick(o[3:2], pc, pf, cc));
    r = o[7] ? z - x - 64'(ci) : z + x + 64'(ci);
    return r[48:0];
  endfunction

  task automatic cyc(input logic [7:0] op, input logic [35:0] mm, input logic [47:0] dd, input logic [47:0] cc,
                     input logic [47:0] pc, input logic ci, input logic ce, input logic ceo, input logic r);
    logic [48:0] n0, n1, n2;
    i0.opmode = op; i0.m = mm; i0.dab = dd; i0.c = cc; i0.pcin = pc; i0.carryin = ci; i0.cep = ce; i0.ceopmode = ceo;
    i1.opmode = op; i1.m = mm; i1.dab = dd; i1.c = cc; i1.pcin = pc; i1.carryin = ci; i1.cep = ce; i1.ceopmode = ceo;
    i2.opmode = op; i2.m = mm; i2.dab = dd; i2.c = cc; i2.pcin = pc; i2.carryin = ci; i2.cep = ce; i2.ceopmode = ceo;
    rst = r;
    #1;
    n2 = alu(op, 48'd0, mm, dd, cc, pc, ci);
    chk("comb_p", 64'(i2.p), 64'(n2[47:0]));
    chk("comb_co", 64'(i2.carryout), 64'(n2[48]));
    chk("comb_pcout", 64'(i2.pcout), 64'(n2[47:0]));
    n0 = alu(op, p0, mm, dd, cc, pc, op[5]);
    n1 = alu(o1, p1, mm, dd, cc, pc, o1[5]);
    @(posedge clk);
    #1;
    if (r) begin
      p0 = '0; c0 = 1'b0; p1 = '0; c1 = 1'b0; o1 = '0;
    end else begin
      if (ce) begin {c0, p0} = n0; {c1, p1} = n1; end
      if (ceo) o1 = op;
    end
    chk("r0_p", 64'(i0.p), 64'(p0));
    chk("r0_co", 64'(i0.carryout), 64'(c0));
    chk("r0_pcout", 64'(i0.pcout), 64'(p0));
    chk("r0_cof", 64'(i0.carryoutf), 64'(c0));
    chk("r1_p", 64'(i1.p), 64'(p1));
    chk("r1_co", 64'(i1.carryout), 64'(c1));
  endtask

  initial begin
    cyc(8'h0D, 36'd5, 48'd0, 48'd10, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("reset_p", 64'(i0.p), 64'd0);
    cyc(8'h0D, 36'd5, 48'd0, 48'd10, 48'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("madd_p", 64'(i0.p), 64'd15);
    chk("madd_co", 64'(i0.carryout), 64'd0);
    cyc(8'h0D, 36'd5, 48'd0, 48'd10, 48'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("oreg_fill", 64'(i1.p), 64'd15);
    cyc(8'h05, 36'd5, 48'd0, 48'd10, 48'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("oreg_lag", 64'(i1.p), 64'd15);
    cyc(8'h05, 36'd5, 48'd0, 48'd10, 48'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("oreg_new", 64'(i1.p), 64'd5);
    cyc(8'h09, 36'd3, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      cyc(8'h09, 36'd3, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("acc_p", 64'(i0.p), 64'(3 * k));
    end
    cyc(8'h09, 36'd3, 48'd0, 48'd0, 48'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("acc_hold", 64'(i0.p), 64'd12);
    cyc(8'h09, 36'd3, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_prio_p", 64'(i0.p), 64'd0);
    chk("rst_prio_co", 64'(i0.carryout), 64'd0);
    cyc(8'h09, 36'd3, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_resume", 64'(i0.p), 64'd3);
    cyc(8'h8F, 36'd0, 48'd7, 48'd5, 48'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("sub_p", 64'(i0.p), 64'hFFFF_FFFF_FFFE);
    chk("sub_co", 64'(i0.carryout), 64'd1);
    cyc(8'h2F, 36'd0, 48'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("wrap_p", 64'(i0.p), 64'd0);
    chk("wrap_co", 64'(i0.carryout), 64'd1);
    for (int k = 0; k < 400; k++)
      cyc(8'($urandom), 36'({$urandom, $urandom}), 48'({$urandom, $urandom}), 48'({$urandom, $urandom}),
          48'({$urandom, $urandom}), 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 29) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/post_adder_acc.md
POST_ADDER_ACC -- requirements
Module: post_adder_acc

Interface
REQ-001 SHALL have parameter PREG, default 1, meaning 1 = P/CARRYOUT registered, 0 = combinational.
REQ-002 SHALL have parameter OPMODEREG, default 1, meaning 1 = opmode captured in a register before use, 0 = used directly.
REQ-003 SHALL have parameter CARRYINSEL, default "OPMODE5", meaning carry-in source: "OPMODE5" = opmode[5], "CARRYIN" = carryin port.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all registers update on posedge clk.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port cep, input, 1 bit: clock enable for P and carry registers.
REQ-007 SHALL have port ceopmode, input, 1 bit: clock enable for the opmode register.
REQ-008 SHALL have port opmode, input, 8 bits: [1:0] X select, [3:2] Z select, [5] carry-in, [7] subtract; [4] and [6] ignored.
REQ-009 SHALL have port m, input, 36 bits: multiplier product from the M stage.
REQ-010 SHALL have port dab, input, 48 bits: concatenated {D[11:0],A[17:0],B[17:0]}.
REQ-011 SHALL have port c, input, 48 bits: C operand.
REQ-012 SHALL have port pcin, input, 48 bits: cascade input.
REQ-013 SHALL have port carryin, input, 1 bit: external carry-in.
REQ-014 SHALL have port p, output, 48 bits: post-adder result.
REQ-015 SHALL have port pcout, output, 48 bits: always equal to p.
REQ-016 SHALL have port carryout, output, 1 bit: post-adder carry/borrow.
REQ-017 SHALL have port carryoutf, output, 1 bit: always equal to carryout.

Function
REQ-018 X mux SHALL select: 0 -> zero; 1 -> m zero-extended to 48 bits; 2 -> p feedback; 3 -> dab.
REQ-019 Z mux SHALL select: 0 -> zero; 1 -> pcin; 2 -> p feedback; 3 -> c.
REQ-020 CIN SHALL be opmode[5] or carryin, per CARRYINSEL; any other CARRYINSEL value SHALL force CIN = 0.
REQ-021 Add (opmode[7]=0) SHALL compute the 49-bit result {co,s} = Z + X + CIN.
REQ-022 Subtract (opmode[7]=1) SHALL compute {co,s} = {0,Z} - ({0,X} + CIN) modulo 2^49; co is bit 48, the borrow.
REQ-023 With PREG=1, on each posedge with cep=1 and rst=0: p <= s and carryout <= co; with cep=0 both SHALL hold.
REQ-024 With PREG=1, latency SHALL be 1 cycle from operand/opmode to p when OPMODEREG=0, and 2 cycles for opmode changes when OPMODEREG=1.
REQ-025 With PREG=0, p and carryout SHALL be combinational, and X/Z selects of 2 (p feedback) SHALL be treated as zero to break the loop.
REQ-026 P feedback with PREG=1 SHALL use the current registered p, making opmode X=1, Z=2 an accumulator: p <= p + m + CIN each enabled cycle.
REQ-027 Overflow SHALL wrap modulo 2^48 in p; the carry out of bit 47 appears only on carryout; there is no saturation.
REQ-028 The opmode register (OPMODEREG=1) SHALL load on posedge when ceopmode=1 and hold otherwise.

Reset
REQ-029 rst=1 at posedge SHALL clear p, carryout and the opmode register to 0 regardless of cep/ceopmode, taking priority over any load.
REQ-030 Deassertion of rst SHALL allow normal operation from the next posedge; a reset mid-accumulation SHALL discard the running sum.
REQ-031 With PREG=0, rst SHALL affect only the opmode register; outputs follow their inputs.

Verification
REQ-032 PREG=1, OPMODEREG=0: opmode=8'h0D (X=m, Z=c), m=36'd5, c=48'd10 -> p=15, carryout=0 one cycle later.
REQ-033 Accumulate: opmode=8'h09 (X=m, Z=p), m=3, cep=1 for 4 cycles after reset -> p = 3, 6, 9, 12; cep=0 -> p holds at 12.
REQ-034 Subtract: opmode=8'h8F (X=dab, Z=c, sub), c=5, dab=7 -> p=48'hFFFF_FFFF_FFFE, carryout=1.
REQ-035 Wrap: opmode=8'h2F (X=dab, Z=c, CIN=1), c=48'hFFFF_FFFF_FFFF, dab=0 -> p=0, carryout=1.
REQ-036 Reset priority: mid-accumulation with p=12, assert rst together with cep=1 -> p=0 and carryout=0 next cycle; the following cycle p=3.
REQ-037 OPMODEREG=1: change opmode from 8'h0D to 8'h05 (Z=zero) -> p shows c+m for one more cycle, then m.
